// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg
// Shared definitions for the fetch-stage sequencer:
//   - fetch_state_e : controller states (IDLE, REQ, WAIT, DROP)
//   - DEFAULT_RESET_PC / DEFAULT_IM_BASE : default parameter values
//   - PC_STEP       : sequential PC increment (one 32-bit instruction)
//   - word_align()  : clears the byte-offset bits of an address
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  // Instructions are word aligned; byte-offset bits of any target are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_out_slot.sv
// fetch_out_slot
// One-entry output register between fetch and decode (the IF/ID slot).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   load_i         : capture instr_i/pc_i/pc_plus4_i and mark the slot valid
//   flush_i        : invalidate the slot; wins over load_i and stall_i
//   stall_i        : decode cannot take the slot this cycle
//   instr_i, pc_i, pc_plus4_i : data to capture
//   valid_o, instr_o, pc_o, pc_plus4_o : registered slot contents
module fetch_out_slot
  import pc_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic        valid_q,    valid_d;
  logic [31:0] instr_q,    instr_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;

  // Next-state of the slot: flush, load, consume or hold.
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    if (flush_i) begin
      // Data fields keep their old value; only the valid bit matters.
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
    end else if (valid_q && !stall_i) begin
      // Decode took the instruction and nothing new arrived.
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      instr_q    <= 32'h0000_0000;
      pc_q       <= 32'h0000_0000;
      pc_plus4_q <= 32'h0000_0000;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
// Fetch-stage sequencer: owns the architectural PC, issues one outstanding
// instruction-memory request at a time and hands fetched words to decode.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   redirect_valid/_pc        : taken branch/jump target; flushes fetch
//   id_stall                  : decode cannot accept the presented instruction
//   im_req/im_addr/im_ready   : request handshake; im_addr is a byte offset
//   im_rvalid/im_rdata        : response (at most one outstanding)
//   if_valid/if_instr/if_pc/if_pc_plus4 : IF/ID register contents
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] IM_BASE  = DEFAULT_IM_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;

  logic         slot_free_s;
  logic         accept_s;
  logic         load_s;
  logic [31:0]  target_s;
  logic [31:0]  pc_plus4_s;

  // A request is only issued when the slot can take its response, which is
  // what makes a skid buffer unnecessary.
  assign slot_free_s = !if_valid || !id_stall;
  assign im_req      = (state_q == REQ) && slot_free_s;
  assign accept_s    = im_req && im_ready;
  assign im_addr     = pc_q - IM_BASE;
  assign target_s    = word_align(redirect_pc);
  assign pc_plus4_s  = pc_q + PC_STEP;

  // Next state and next PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load_s  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_d = target_s;
          // An accepted request now returns stale data and must be dropped.
          if (accept_s) begin
            state_d = DROP;
          end else begin
            state_d = REQ;
          end
        end else if (accept_s) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (im_rvalid) begin
          if (redirect_valid) begin
            pc_d = target_s;
          end else begin
            load_s = 1'b1;
            pc_d   = pc_plus4_s;
          end
          state_d = REQ;
        end else if (redirect_valid) begin
          pc_d    = target_s;
          state_d = DROP;
        end else begin
          state_d = WAIT;
        end
      end
      DROP: begin
        // Last redirect wins while the stale response drains.
        if (redirect_valid) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
        if (im_rvalid) begin
          state_d = REQ;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = pc_q;
      end
    endcase
  end

  // Controller state and architectural PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_out_slot u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_s),
    .flush_i    (redirect_valid),
    .stall_i    (id_stall),
    .instr_i    (im_rdata),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4_s),
    .valid_o    (if_valid),
    .instr_o    (if_instr),
    .pc_o       (if_pc),
    .pc_plus4_o (if_pc_plus4)
  );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl
// Directed bench for pc_fetch_ctrl. Inputs change 1 time unit after a rising
// edge; outputs are sampled on the falling edge. A small memory model answers
// each accepted request mem_lat cycles later with rdata = addr ^ 32'hA5A5_0000.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_stall = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready = 1'b1;
  logic        im_rvalid = 1'b0;
  logic [31:0] im_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat = 1;
  int mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_stall(id_stall),
    .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  always #5 clk = ~clk;

  // Memory model: decides at the falling edge whether the coming rising edge
  // accepts a request, and presents the response for the edge mem_lat later.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_cnt   = 0;
      im_rvalid = 1'b0;
    end else begin
      im_rvalid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt = mem_cnt - 1;
        if (mem_cnt == 0) begin
          im_rvalid = 1'b1;
          im_rdata  = mem_addr ^ K;
        end
      end
      if (im_req && im_ready) begin
        mem_addr = im_addr;
        mem_cnt  = mem_lat;
      end
    end
  end

  task automatic wait_valid(input int max_cyc, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      cyc = cyc + 1;
      if (if_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(input int max_cyc, output bit ok, output bit saw_valid);
    ok = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (if_valid === 1'b1) saw_valid = 1'b1;
      if (im_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL reset_im_req: got %0b want 0", im_req); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_if_valid: got %0b want 0", if_valid); end
    n_cmp++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL reset_if_instr: got %h want 0", if_instr); end
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
    n_cmp++; if (if_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL reset_if_pc_plus4: got %h want 0", if_pc_plus4); end
    n_cmp++; if (im_addr !== 32'h0) begin n_err++; $display("FAIL reset_im_addr: got %h want 0", im_addr); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL idle_im_req: got %0b want 0", im_req); end
    @(negedge clk);
    n_cmp++; if (im_req !== 1'b1) begin n_err++; $display("FAIL first_im_req: got %0b want 1", im_req); end
    n_cmp++; if (im_addr !== 32'h0) begin n_err++; $display("FAIL first_im_addr: got %h want 0", im_addr); end
  endtask

  task automatic test_zero_wait;
    bit ok;
    int cyc;
    logic [31:0] exp_pc;
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'h0000_3000 + 32'(4 * k);
      wait_valid(6, ok, cyc);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL zw_timeout[%0d]: got no if_valid want if_valid", k); end
      n_cmp++; if (cyc != 2) begin n_err++; $display("FAIL zw_spacing[%0d]: got %0d cycles want 2", k, cyc); end
      n_cmp++; if (if_pc !== exp_pc) begin n_err++; $display("FAIL zw_if_pc[%0d]: got %h want %h", k, if_pc, exp_pc); end
      n_cmp++; if (if_instr !== ((exp_pc - 32'h3000) ^ K)) begin n_err++; $display("FAIL zw_if_instr[%0d]: got %h want %h", k, if_instr, (exp_pc - 32'h3000) ^ K); end
      n_cmp++; if (if_pc_plus4 !== exp_pc + 32'd4) begin n_err++; $display("FAIL zw_if_pc_plus4[%0d]: got %h want %h", k, if_pc_plus4, exp_pc + 32'd4); end
    end
  endtask

  task automatic test_stall;
    bit found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (!im_req && !if_valid) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL stall_find_wait: got no WAIT cycle want one"); end
    id_stall = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL stall_im_req[%0d]: got %0b want 0", i, im_req); end
      n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL stall_if_valid[%0d]: got %0b want 1", i, if_valid); end
      n_cmp++; if (if_pc !== 32'h0000_300C) begin n_err++; $display("FAIL stall_if_pc[%0d]: got %h want 0000300c", i, if_pc); end
      n_cmp++; if (if_instr !== 32'hA5A5_000C) begin n_err++; $display("FAIL stall_if_instr[%0d]: got %h want a5a5000c", i, if_instr); end
    end
    @(posedge clk); #1;
    id_stall = 1'b0;
    @(negedge clk);
    n_cmp++; if (im_req !== 1'b1) begin n_err++; $display("FAIL unstall_im_req: got %0b want 1", im_req); end
    n_cmp++; if (im_addr !== 32'h0000_0010) begin n_err++; $display("FAIL unstall_im_addr: got %h want 00000010", im_addr); end
    n_cmp++; if (if_pc !== 32'h0000_300C) begin n_err++; $display("FAIL unstall_if_pc: got %h want 0000300c", if_pc); end
  endtask

  task automatic test_redirect_wait;
    bit ok;
    bit saw;
    int cyc;
    @(posedge clk); #1;
    mem_lat = 3;
    wait_valid(4, ok, cyc);
    n_cmp++; if (!ok || if_pc !== 32'h0000_3010) begin n_err++; $display("FAIL rw_pre_if_pc: got %h want 00003010", if_pc); end
    @(posedge clk); #1;
    n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL rw_in_wait_im_req: got %0b want 0", im_req); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3040;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    mem_lat = 1;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rw_flush_if_valid: got %0b want 0", if_valid); end
    n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL rw_drop_im_req: got %0b want 0", im_req); end
    wait_req(6, ok, saw);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rw_req_timeout: got no im_req want im_req"); end
    n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL rw_discard: got if_valid=1 want 0"); end
    n_cmp++; if (im_addr !== 32'h0000_0040) begin n_err++; $display("FAIL rw_im_addr: got %h want 00000040", im_addr); end
    wait_valid(4, ok, cyc);
    n_cmp++; if (!ok || if_pc !== 32'h0000_3040) begin n_err++; $display("FAIL rw_if_pc: got %h want 00003040", if_pc); end
    n_cmp++; if (if_instr !== 32'hA5A5_0040) begin n_err++; $display("FAIL rw_if_instr: got %h want a5a50040", if_instr); end
    n_cmp++; if (if_pc_plus4 !== 32'h0000_3044) begin n_err++; $display("FAIL rw_if_pc_plus4: got %h want 00003044", if_pc_plus4); end
  endtask

  task automatic test_redirect_rvalid;
    bit ok = 1'b0;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (im_rvalid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_rvalid_timeout: got no im_rvalid want im_rvalid"); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3100;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rr_no_capture_valid: got %0b want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0000_3040) begin n_err++; $display("FAIL rr_no_capture_pc: got %h want 00003040", if_pc); end
    n_cmp++; if (im_req !== 1'b1) begin n_err++; $display("FAIL rr_im_req: got %0b want 1", im_req); end
    n_cmp++; if (im_addr !== 32'h0000_0100) begin n_err++; $display("FAIL rr_im_addr: got %h want 00000100", im_addr); end
    wait_valid(4, ok, cyc);
    n_cmp++; if (!ok || if_pc !== 32'h0000_3100) begin n_err++; $display("FAIL rr_if_pc: got %h want 00003100", if_pc); end
  endtask

  task automatic test_drop_double;
    bit ok;
    bit saw;
    int cyc;
    @(posedge clk); #1;
    mem_lat = 3;
    n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL dd_in_wait_im_req: got %0b want 0", im_req); end
    wait_valid(4, ok, cyc);
    n_cmp++; if (!ok || if_pc !== 32'h0000_3104) begin n_err++; $display("FAIL dd_pre_if_pc: got %h want 00003104", if_pc); end
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3200;
    @(posedge clk); #1;
    redirect_pc    = 32'h0000_3303;
    n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL dd_drop_im_req: got %0b want 0", im_req); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL dd_flush_if_valid: got %0b want 0", if_valid); end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    mem_lat = 1;
    wait_req(6, ok, saw);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL dd_req_timeout: got no im_req want im_req"); end
    n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL dd_discard: got if_valid=1 want 0"); end
    n_cmp++; if (im_addr !== 32'h0000_0300) begin n_err++; $display("FAIL dd_im_addr: got %h want 00000300", im_addr); end
    wait_valid(4, ok, cyc);
    n_cmp++; if (!ok || if_pc !== 32'h0000_3300) begin n_err++; $display("FAIL dd_if_pc: got %h want 00003300", if_pc); end
    n_cmp++; if (if_instr !== 32'hA5A5_0300) begin n_err++; $display("FAIL dd_if_instr: got %h want a5a50300", if_instr); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int cyc;
    @(posedge clk); #1;
    n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL rm_in_wait_im_req: got %0b want 0", im_req); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL rm_im_req: got %0b want 0", im_req); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rm_if_valid: got %0b want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rm_if_pc: got %h want 0", if_pc); end
    n_cmp++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL rm_if_instr: got %h want 0", if_instr); end
    n_cmp++; if (if_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL rm_if_pc_plus4: got %h want 0", if_pc_plus4); end
    n_cmp++; if (im_addr !== 32'h0) begin n_err++; $display("FAIL rm_im_addr: got %h want 0", im_addr); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL rm_idle_im_req: got %0b want 0", im_req); end
    @(negedge clk);
    n_cmp++; if (im_req !== 1'b1) begin n_err++; $display("FAIL rm_first_im_req: got %0b want 1", im_req); end
    n_cmp++; if (im_addr !== 32'h0) begin n_err++; $display("FAIL rm_first_im_addr: got %h want 0", im_addr); end
    wait_valid(4, ok, cyc);
    n_cmp++; if (!ok || if_pc !== 32'h0000_3000) begin n_err++; $display("FAIL rm_if_pc_after: got %h want 00003000", if_pc); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_drop_double();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case a stimulus loop ever stalls.
  initial begin
    #20000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
